// File: rtl/game_pkg.sv
// Shared game constants, sprite identifiers and player state encoding.
// Used by the per-player motion controllers and by the renderer.
package game_pkg;

    typedef enum logic [3:0] {
        OBJECT_NONE,
        OBJECT_PLAYER1,
        OBJECT_PLAYER1_SHIELD,
        OBJECT_PLAYER1_SQUAT,
        OBJECT_PLAYER2,
        OBJECT_PLAYER2_SHIELD,
        OBJECT_PLAYER2_SQUAT,
        OBJECT_BULLET
    } ObjectID;

    localparam int STEP_X   = 6;
    localparam int V        = 20;
    localparam int MAX_J    = 80;
    localparam int LIMIT_X  = 480;
    localparam int HP_WIDTH = 3;

    localparam int JUMP_STEP           = MAX_J / V;
    localparam int FIRE_COOLDOWN_DFLT  = 20;
    localparam int INVULN_FRAMES_DFLT  = 30;

    typedef enum logic [2:0] {
        PS_IDLE,
        PS_GROUND,
        PS_RISE,
        PS_FALL,
        PS_SQUAT,
        PS_SHIELD,
        PS_DEAD
    } PlayerState;

    typedef enum logic [1:0] {
        POSE_STAND,
        POSE_SHIELD,
        POSE_SQUAT
    } PoseSel;

    function automatic ObjectID pose_to_object(input int player_idx, input PoseSel pose);
        ObjectID obj;
        if (player_idx == 2) begin
            case (pose)
                POSE_SHIELD: obj = OBJECT_PLAYER2_SHIELD;
                POSE_SQUAT:  obj = OBJECT_PLAYER2_SQUAT;
                default:     obj = OBJECT_PLAYER2;
            endcase
        end else begin
            case (pose)
                POSE_SHIELD: obj = OBJECT_PLAYER1_SHIELD;
                POSE_SQUAT:  obj = OBJECT_PLAYER1_SQUAT;
                default:     obj = OBJECT_PLAYER1;
            endcase
        end
        return obj;
    endfunction

endpackage

// File: rtl/player_motion_ctrl_tick_counter.sv
// Frame-tick down-counter: loads a value on a tick, otherwise decrements
// towards zero on each tick and holds at zero.
module tick_counter #(
    parameter int WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_tick,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_tick) begin
            if (i_load)
                r_count <= i_load_val;
            else if (r_count != '0)
                r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-player motion/state controller: turns sampled button levels into position,
// jump height, pose, HP and shot requests, advancing once per video frame tick.
module player_motion_ctrl
    import game_pkg::*;
#(
    parameter int PLAYER_IDX    = 1,
    parameter int INIT_X        = -240,
    parameter int HP_INIT       = 5,
    parameter int FIRE_COOLDOWN = FIRE_COOLDOWN_DFLT,
    parameter int INVULN_FRAMES = INVULN_FRAMES_DFLT
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_game_start,
    input  logic                       i_frame_tick,
    input  logic                       i_left,
    input  logic                       i_right,
    input  logic                       i_jump,
    input  logic                       i_squat,
    input  logic                       i_shield,
    input  logic                       i_fire,
    input  logic                       i_hit,
    output logic signed [11:0]         o_x,
    output logic [6:0]                 o_y_off,
    output ObjectID                    o_pose,
    output logic [HP_WIDTH-1:0]        o_hp,
    output logic                       o_fire,
    output logic                       o_dead
);

    localparam int CD_W  = (FIRE_COOLDOWN < 1) ? 1 : $clog2(FIRE_COOLDOWN + 1);
    localparam int INV_W = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1);
    localparam int JC_W  = $clog2(V);
    localparam logic signed [12:0] C_STEP = 13'(STEP_X);
    localparam logic signed [12:0] C_LIM  = 13'(LIMIT_X);

    PlayerState            r_state;
    logic signed [11:0]    r_x;
    logic [6:0]            r_y;
    logic [JC_W-1:0]       r_jc;
    logic [HP_WIDTH-1:0]   r_hp;
    logic                  r_fire;
    logic                  r_dead;
    logic                  r_hit_pend;
    ObjectID               r_pose;

    PlayerState            w_state_nxt;
    logic signed [11:0]    w_x_nxt;
    logic [6:0]            w_y_nxt;
    logic [JC_W-1:0]       w_jc_nxt;
    logic [JC_W-1:0]       w_jc_inc;
    logic [HP_WIDTH-1:0]   w_hp_nxt;
    logic                  w_active;
    logic                  w_hit_take;
    logic                  w_fire_take;
    logic                  w_move;
    logic                  w_right;
    logic                  w_left;
    logic signed [12:0]    w_dx;
    logic signed [12:0]    w_x_sum;
    logic signed [11:0]    w_x_clamp;
    PoseSel                w_pose_sel;
    logic                  w_cd_zero;
    logic                  w_inv_zero;
    logic [CD_W-1:0]       w_cd;
    logic [INV_W-1:0]      w_inv;

    tick_counter #(.WIDTH(CD_W)) u_cd (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (i_game_start),
        .i_tick     (i_frame_tick),
        .i_load     (w_fire_take),
        .i_load_val (CD_W'(FIRE_COOLDOWN)),
        .o_count    (w_cd),
        .o_zero     (w_cd_zero)
    );

    tick_counter #(.WIDTH(INV_W)) u_inv (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (i_game_start),
        .i_tick     (i_frame_tick),
        .i_load     (w_hit_take),
        .i_load_val (INV_W'(INVULN_FRAMES)),
        .o_count    (w_inv),
        .o_zero     (w_inv_zero)
    );

    // Player 2 faces the other way, so its left/right buttons are swapped.
    always_comb begin
        w_right = (PLAYER_IDX == 2) ? i_left  : i_right;
        w_left  = (PLAYER_IDX == 2) ? i_right : i_left;
        w_dx    = '0;
        if (w_right && !w_left)
            w_dx = C_STEP;
        else if (w_left && !w_right)
            w_dx = -C_STEP;
        w_x_sum = $signed({r_x[11], r_x}) + w_dx;
        if (w_x_sum > C_LIM)
            w_x_clamp = 12'(C_LIM);
        else if (w_x_sum < -C_LIM)
            w_x_clamp = 12'(-C_LIM);
        else
            w_x_clamp = w_x_sum[11:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_jc_nxt    = r_jc;
        w_hp_nxt    = r_hp;
        w_hit_take  = 1'b0;
        w_fire_take = 1'b0;
        w_move      = 1'b0;
        w_jc_inc    = r_jc + JC_W'(1);
        w_active    = (r_state != PS_IDLE) && (r_state != PS_DEAD);

        if (w_active && i_frame_tick) begin
            w_hit_take  = (r_hit_pend || i_hit) && (r_state != PS_SHIELD) && w_inv_zero;
            w_fire_take = i_fire && w_cd_zero &&
                          (r_state inside {PS_GROUND, PS_RISE, PS_FALL});

            case (r_state)
                PS_GROUND: begin
                    if (i_shield)
                        w_state_nxt = PS_SHIELD;
                    else if (i_squat)
                        w_state_nxt = PS_SQUAT;
                    else if (i_jump) begin
                        w_state_nxt = PS_RISE;
                        w_y_nxt     = 7'(JUMP_STEP);
                        w_jc_nxt    = '0;
                    end else
                        w_move = 1'b1;
                end
                PS_RISE: begin
                    w_move   = 1'b1;
                    w_y_nxt  = r_y + 7'(JUMP_STEP);
                    w_jc_nxt = w_jc_inc;
                    if (w_jc_inc == JC_W'(V - 1))
                        w_state_nxt = PS_FALL;
                end
                PS_FALL: begin
                    w_move  = 1'b1;
                    w_y_nxt = r_y - 7'(JUMP_STEP);
                    if (r_y == 7'(JUMP_STEP))
                        w_state_nxt = PS_GROUND;
                end
                PS_SQUAT: begin
                    if (!i_squat)
                        w_state_nxt = PS_GROUND;
                end
                PS_SHIELD: begin
                    if (!i_shield)
                        w_state_nxt = PS_GROUND;
                end
                default: ;
            endcase

            if (w_move)
                w_x_nxt = w_x_clamp;

            // A fatal hit wins over whatever transition movement chose.
            if (w_hit_take && (r_hp != '0)) begin
                w_hp_nxt = r_hp - HP_WIDTH'(1);
                if (r_hp == HP_WIDTH'(1)) begin
                    w_state_nxt = PS_DEAD;
                    w_y_nxt     = '0;
                end
            end
        end
    end

    always_comb begin
        case (w_state_nxt)
            PS_SHIELD: w_pose_sel = POSE_SHIELD;
            PS_SQUAT:  w_pose_sel = POSE_SQUAT;
            default:   w_pose_sel = POSE_STAND;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_game_start) begin
            r_state    <= i_rst ? PS_IDLE : PS_GROUND;
            r_x        <= 12'(INIT_X);
            r_y        <= '0;
            r_jc       <= '0;
            r_hp       <= HP_WIDTH'(HP_INIT);
            r_fire     <= 1'b0;
            r_dead     <= 1'b0;
            r_hit_pend <= 1'b0;
            r_pose     <= pose_to_object(PLAYER_IDX, POSE_STAND);
        end else if (i_frame_tick) begin
            r_state    <= w_state_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_jc       <= w_jc_nxt;
            r_hp       <= w_hp_nxt;
            r_fire     <= w_fire_take;
            r_dead     <= r_dead || (w_state_nxt == PS_DEAD);
            r_hit_pend <= 1'b0;
            r_pose     <= pose_to_object(PLAYER_IDX, w_pose_sel);
        end else begin
            r_fire <= 1'b0;
            if (i_hit)
                r_hit_pend <= 1'b1;
        end
    end

    assign o_x     = r_x;
    assign o_y_off = r_y;
    assign o_pose  = r_pose;
    assign o_hp    = r_hp;
    assign o_fire  = r_fire;
    assign o_dead  = r_dead;

endmodule
